// File: rtl/alu_seq.sv
// alu_seq: registered 16-command ALU with valid/ready handshakes, status flags,
// a tri-state result bus and an optional iterative restoring divider.
// Optional feature macro: ALU_DIV_EN (defined = multi-cycle divider and DIV_BUSY
// state; undefined = DIV finishes in one cycle with result 0 and flag_dz=1).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         command,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               oe,
  output logic [2*WIDTH-1:0] y,
  output logic               flag_zero,
  output logic               flag_dz
);

  localparam int RW = 2 * WIDTH;

  localparam logic [3:0] CMD_ADD  = 4'h0;
  localparam logic [3:0] CMD_INC  = 4'h1;
  localparam logic [3:0] CMD_SUB  = 4'h2;
  localparam logic [3:0] CMD_DEC  = 4'h3;
  localparam logic [3:0] CMD_MUL  = 4'h4;
  localparam logic [3:0] CMD_DIV  = 4'h5;
  localparam logic [3:0] CMD_SHL  = 4'h6;
  localparam logic [3:0] CMD_SHR  = 4'h7;
  localparam logic [3:0] CMD_AND  = 4'h8;
  localparam logic [3:0] CMD_OR   = 4'h9;
  localparam logic [3:0] CMD_INV  = 4'hA;
  localparam logic [3:0] CMD_NAND = 4'hB;
  localparam logic [3:0] CMD_NOR  = 4'hC;
  localparam logic [3:0] CMD_XOR  = 4'hD;
  localparam logic [3:0] CMD_XNOR = 4'hE;

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, DONE, DIV_BUSY} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t           state_reg, state_next;
  logic [RW-1:0]    result_reg;
  logic             zero_reg;
  logic             dz_reg;
  logic             accept;
  logic             is_div;
  logic [RW-1:0]    alu_res;
  logic             alu_dz;
  logic [RW-1:0]    ax, bx;

  assign ax     = RW'(a);
  assign bx     = RW'(b);
  assign accept = in_valid && in_ready;

`ifdef ALU_DIV_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] divisor_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic             div_last;

  assign is_div   = (command == CMD_DIV);
  assign div_last = (state_reg == DIV_BUSY) && (cnt_reg == CNT_LAST);

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits. A zero divisor always "fits", which
  // yields an all-ones quotient without any special casing.
  always_comb begin
    shifted  = {rem_reg, quo_reg[WIDTH-1]};
    ge       = (shifted >= {1'b0, divisor_reg});
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo_reg[WIDTH-2:0], 1'b0};
    if (ge) begin
      rem_next = shifted[WIDTH-1:0] - divisor_reg;
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Divider iteration registers: loaded on DIV acceptance, stepped while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      cnt_reg     <= '0;
    end else if (accept && is_div) begin
      quo_reg     <= a;
      rem_reg     <= '0;
      divisor_reg <= b;
      cnt_reg     <= '0;
    end else if (state_reg == DIV_BUSY) begin
      quo_reg <= quo_next;
      rem_reg <= rem_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  assign is_div = 1'b0;
`endif

  // Single-cycle datapath for every command that completes on acceptance.
  always_comb begin
    alu_res = '0;
    alu_dz  = 1'b0;
    case (command)
      CMD_ADD:  alu_res = ax + bx;
      CMD_INC:  alu_res = ax + RW'(1);
      CMD_SUB:  alu_res = ax - bx;
      CMD_DEC:  alu_res = ax - RW'(1);
      CMD_MUL:  alu_res = ax * bx;
      CMD_DIV: begin
        // Without the divider the command still completes, marked as unusable.
        alu_res = '0;
        alu_dz  = 1'b1;
      end
      CMD_SHL:  alu_res = (bx >= RW'(RW)) ? '0 : (ax << bx);
      CMD_SHR:  alu_res = (bx >= RW'(RW)) ? '0 : (ax >> bx);
      CMD_AND:  alu_res = ax & bx;
      CMD_OR:   alu_res = ax | bx;
      CMD_INV:  alu_res = ~ax;
      CMD_NAND: alu_res = ~(ax & bx);
      CMD_NOR:  alu_res = ~(ax | bx);
      CMD_XOR:  alu_res = ax ^ bx;
      CMD_XNOR: alu_res = ~(ax ^ bx);
      default:  alu_res = ax;
    endcase
  end

  // Handshake FSM: next state and ready/valid outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = is_div ? state_t'(1'b0 ? IDLE : state_next_div()) : DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_next = is_div ? state_next_div() : DONE;
          else          state_next = IDLE;
        end
      end
`ifdef ALU_DIV_EN
      DIV_BUSY: begin
        if (div_last) state_next = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State to enter when a DIV is accepted.
  function automatic state_t state_next_div();
`ifdef ALU_DIV_EN
    return DIV_BUSY;
`else
    return DONE;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Result register and flags: written on single-cycle acceptance or when the
  // divider finishes; otherwise held, so the value survives consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      zero_reg   <= 1'b0;
      dz_reg     <= 1'b0;
    end else if (accept && !is_div) begin
      result_reg <= alu_res;
      zero_reg   <= (alu_res == '0);
      dz_reg     <= alu_dz;
    end
`ifdef ALU_DIV_EN
    else if (div_last) begin
      result_reg <= RW'(quo_next);
      zero_reg   <= (quo_next == '0);
      dz_reg     <= (divisor_reg == '0);
    end
`endif
  end

  assign y         = oe ? result_reg : 'z;
  assign flag_zero = zero_reg;
  assign flag_dz   = dz_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized checks of alu_seq against a plain
// arithmetic reference model. Honours ALU_DIV_EN the same way as the design.
module tb_alu_seq;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        oe;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  command;
  logic        in_ready;
  logic        out_valid;
  logic        flag_zero;
  logic        flag_dz;
  wire  [15:0] y;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .command(command), .out_valid(out_valid),
    .out_ready(out_ready), .oe(oe), .y(y),
    .flag_zero(flag_zero), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: 16-bit modular arithmetic on zero-extended operands.
  function automatic logic [15:0] model_y(input int unsigned ai, input int unsigned bi,
                                          input logic [3:0] c);
    int unsigned r;
    case (c)
      4'h0: r = ai + bi;
      4'h1: r = ai + 1;
      4'h2: r = ai - bi;
      4'h3: r = ai - 1;
      4'h4: r = ai * bi;
`ifdef ALU_DIV_EN
      4'h5: r = (bi == 0) ? 32'hFF : ai / bi;
`else
      4'h5: r = 0;
`endif
      4'h6: r = (bi >= 16) ? 0 : (ai << bi);
      4'h7: r = (bi >= 16) ? 0 : (ai >> bi);
      4'h8: r = ai & bi;
      4'h9: r = ai | bi;
      4'hA: r = ~ai;
      4'hB: r = ~(ai & bi);
      4'hC: r = ~(ai | bi);
      4'hD: r = ai ^ bi;
      4'hE: r = ~(ai ^ bi);
      default: r = ai;
    endcase
    return r[15:0];
  endfunction

  function automatic logic model_dz(input int unsigned bi, input logic [3:0] c);
`ifdef ALU_DIV_EN
    return (c == 4'h5) && (bi == 0);
`else
    return (c == 4'h5);
`endif
  endfunction

  function automatic int model_lat(input logic [3:0] c);
`ifdef ALU_DIV_EN
    return (c == 4'h5) ? W + 1 : 1;
`else
    return 1;
`endif
  endfunction

  // Issue one op with out_ready=1, measure latency, check result and flags.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] tc,
                        input string tag);
    int          lat;
    logic        busy_ok;
    logic [15:0] ey;
    ey = model_y(ta, tb, tc);
    @(negedge clk);
    a = ta; b = tb; command = tc; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(model_lat(tc)));
    check({tag, ".busy_in_ready_low"}, 32'(busy_ok), 32'd1);
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".flag_zero"}, 32'(flag_zero), 32'(ey == 16'h0));
    check({tag, ".flag_dz"}, 32'(flag_dz), 32'(model_dz(tb, tc)));
    $display("[TB] %s cmd=%h a=%h b=%h y=%h zero=%b dz=%b lat=%0d",
             tag, tc, ta, tb, y, flag_zero, flag_dz, lat);
  endtask

  initial begin
    logic [15:0] zz;
    logic [3:0]  rc;
    logic [7:0]  ra, rb;
    zz = 'z;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; oe = 1'b1;
    a = '0; b = '0; command = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.y", 32'(y), 32'h0);
    check("reset.flag_zero", 32'(flag_zero), 32'd0);
    check("reset.flag_dz", 32'(flag_dz), 32'd0);
    $display("[TB] reset out_valid=%b in_ready=%b y=%h", out_valid, in_ready, y);

    // Directed operations.
    run_op(8'hFF, 8'h01, 4'h0, "add_carry");
    run_op(8'h03, 8'h05, 4'h2, "sub_wrap");
    run_op(8'h00, 8'h00, 4'h3, "dec_zero");
    run_op(8'h0F, 8'h00, 4'hA, "inv");
    run_op(8'h81, 8'h01, 4'h6, "shl");
    run_op(8'h80, 8'h10, 4'h7, "shr_big");
    run_op(8'hC8, 8'h07, 4'h5, "div");
    run_op(8'hC8, 8'h00, 4'h5, "div_by_zero");
    run_op(8'h05, 8'h05, 4'h8, "and");

    // Backpressure: MUL result held while out_ready=0.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; command = 4'h4; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = 8'h00; b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("hold.y", 32'(y), 32'hFE01);
      check("hold.out_valid", 32'(out_valid), 32'd1);
      check("hold.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    oe = 1'b0;
    #1;
    check("oe_off.y", 32'(y), 32'(zz));
    check("oe_off.out_valid", 32'(out_valid), 32'd1);
    oe = 1'b1;
    a = 8'h01; b = 8'h01; command = 4'h0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("overlap.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("overlap.y", 32'(y), 32'h0002);
    check("overlap.out_valid", 32'(out_valid), 32'd1);
    $display("[TB] overlap mul consumed, add y=%h", y);
    @(negedge clk);
    check("overlap.consumed", 32'(out_valid), 32'd0);
    check("overlap.y_retained", 32'(y), 32'h0002);

    // Reset in the middle of a division, after a divide-by-zero set flag_dz.
    run_op(8'hC8, 8'h00, 4'h5, "div_by_zero2");
    @(negedge clk);
    a = 8'hC8; b = 8'h07; command = 4'h5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.y", 32'(y), 32'h0);
    check("midrst.flag_dz", 32'(flag_dz), 32'd0);
    check("midrst.flag_zero", 32'(flag_zero), 32'd0);
    $display("[TB] midrst out_valid=%b y=%h dz=%b", out_valid, y, flag_dz);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      run_op(ra, rb, rc, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational 16-command ALU. It keeps the same 4-bit command encoding and the tri-state result bus, and adds:
- valid/ready handshakes on input and output
- a registered result
- status flags
- an iterative multi-cycle divider

It sits between the operand/command issue logic and the shared result bus; the bus owner drives oe.

Parameters:
WIDTH, 8, operand width in bits (>=2); result width is 2*WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand/command presented
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
command  input  4  0 ADD, 1 INC, 2 SUB, 3 DEC, 4 MUL, 5 DIV, 6 SHL, 7 SHR, 8 AND, 9 OR, A INV, B NAND, C NOR, D XOR, E XNOR, F BUF
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  consumer takes result this cycle
oe  input  1  output enable for y (combinational)
y  output  2*WIDTH  result when oe=1, all-Z when oe=0
flag_zero  output  1  held result == 0
flag_dz  output  1  held result came from DIV with b==0

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, out_valid=0, result register=0, flag_zero=0, flag_dz=0.
  - rst overrides everything, including a division in progress; the aborted operation is discarded with no output.
- Acceptance: an operation is accepted when in_valid && in_ready at the rising edge; a, b and command are captured on that edge.
- FSM states: IDLE, DIV_BUSY, DONE.
  - IDLE: in_ready=1, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
  - DIV_BUSY: in_ready=0, out_valid=0.
- Transitions:
  - IDLE + accept of a non-DIV op -> DONE.
  - IDLE + accept of DIV -> DIV_BUSY.
  - DONE + out_ready, no new accept -> IDLE.
  - DONE + out_ready + accept -> DONE (non-DIV) or DIV_BUSY (DIV); the old result is consumed and the new op captured on the same edge.
  - DONE + !out_ready -> DONE; the result, flags and y are held stable.
  - DIV_BUSY -> DONE after the final iteration.
- Latency:
  - Non-DIV: result and out_valid appear the cycle after acceptance (1 cycle); sustained throughput 1 op/cycle while out_ready=1.
  - DIV: restoring shift-subtract, one quotient bit per cycle, WIDTH iterations; out_valid asserts WIDTH+1 cycles after acceptance.
- Arithmetic: all operations are evaluated in 2*WIDTH bits, with a and b zero-extended first; results are modulo 2^(2*WIDTH).
  - ADD: a+b; carry appears in bit WIDTH.
  - INC: a+1.
  - SUB: a-b; a<b wraps, e.g. WIDTH=8, 3-5 = 0xFFFE.
  - DEC: a-1; a=0 gives all ones.
  - MUL: full 2*WIDTH product.
  - DIV: quotient a/b in the low WIDTH bits, upper bits 0.
  - DIV with b==0: quotient all ones in the low WIDTH bits, flag_dz=1, same latency.
  - SHL/SHR: shift zero-extended a by b; b >= 2*WIDTH gives 0.
  - AND, OR, XOR, INV, NAND, NOR, XNOR: bitwise on zero-extended operands, so INV/NAND/NOR/XNOR set the upper WIDTH bits to 1.
  - BUF: a, zero-extended.
- Flags:
  - flag_zero and flag_dz update together with the result register.
  - flag_dz=0 for every non-DIV op.
- Tri-state output: y = oe ? result register : all-Z.
  - oe does not affect the handshake or the state.
  - The result register stays readable after consumption until it is overwritten.
- in_valid during DIV_BUSY is ignored; upstream must hold its op until in_ready.

Optional Feature:
ALU_DIV_EN
- Defined: iterative divider and DIV_BUSY state implemented as above.
- Undefined: no divider logic and no DIV_BUSY state.
  - DIV completes in 1 cycle like other ops.
  - Result 0, flag_dz=1 regardless of b.

Test Plan:
- Reset, then WIDTH=8, oe=1, out_ready=1: ADD a=0xFF b=0x01 -> out_valid exactly 1 cycle later, y=0x0100, flag_zero=0.
- SUB a=3 b=5 -> y=0xFFFE. INV a=0x0F -> y=0xFFF0. SHL a=0x81 b=1 -> y=0x0102. SHR a=0x80 b=16 -> y=0x0000, flag_zero=1.
- DIV a=200 b=7 -> in_ready=0 for 8 cycles; out_valid at cycle 9; y=0x001C.
- DIV a=200 b=0 -> y=0x00FF, flag_dz=1. With ALU_DIV_EN undefined: 1 cycle, y=0, flag_dz=1.
- Backpressure: MUL 0xFF*0xFF with out_ready=0 for 5 cycles -> y=0xFE01 held, in_ready=0. Then out_ready=1 with ADD 1+1 presented -> MUL consumed and ADD captured on the same edge; next cycle y=0x0002.
- rst=1 mid-DIV (cycle 4) -> next cycle IDLE, out_valid=0, y=0 (oe=1), flag_dz=0. With oe=0 at any time -> y all-Z while out_valid is unchanged.
